// File: rtl/exec_alu_sequencer.sv
// exec_alu_sequencer: EX-stage ALU control decode with
// multi-cycle multiply sequencing, stall, flush and illegal flag.
package exec_alu_pkg;
  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_JUMP     = 6'h02;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_MOV      = 6'h0F;
  localparam logic [5:0] OP_LDB      = 6'h20;
  localparam logic [5:0] OP_LDW      = 6'h23;
  localparam logic [5:0] OP_STB      = 6'h28;
  localparam logic [5:0] OP_STW      = 6'h2B;
  localparam logic [5:0] OP_TLBWRITE = 6'h30;
  localparam logic [5:0] OP_IRET     = 6'h31;

  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam int unsigned ALUOP_ADD  = 1;
  localparam int unsigned ALUOP_SUB  = 2;
  localparam int unsigned ALUOP_MOV  = 3;
  localparam int unsigned ALUOP_JUMP = 4;
  localparam int unsigned ALUOP_MUL  = 5;
endpackage

module exec_alu_sequencer #(
  parameter int MUL_LATENCY       = 4,
  parameter int ALUOP_W           = 5,
  parameter int EXCEPT_ON_UNKNOWN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               flush,
  output logic [ALUOP_W-1:0] aluop_out,
  output logic               out_valid,
  output logic               mul_start,
  output logic               stall_out,
  output logic               illegal_out
);
  import exec_alu_pkg::*;

  localparam int CW = $clog2(MUL_LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ALUOP_W-1:0]   aluop_q, aluop_d;
  logic                 ov_q, ov_d;
  logic                 ms_q, ms_d;
  logic                 ill_q, ill_d;

  logic                 is_ls, is_hold;
  logic                 dec_ok, dec_hold, dec_mul;
  logic [ALUOP_W-1:0]   dec_op;

  assign is_ls = (opcode == OP_LDB) || (opcode == OP_LDW) ||
                 (opcode == OP_STB) || (opcode == OP_STW);
  assign is_hold = (opcode == OP_TLBWRITE) ||
                   (opcode == OP_IRET);

  // Opcode/funct decode into ALU op class
  always_comb begin
    dec_ok   = 1'b1;
    dec_hold = 1'b0;
    dec_mul  = 1'b0;
    dec_op   = aluop_q;
    unique case (1'b1)
      is_ls:                dec_op = ALUOP_W'(ALUOP_ADD);
      (opcode == OP_BEQ):   dec_op = ALUOP_W'(ALUOP_SUB);
      (opcode == OP_MOV):   dec_op = ALUOP_W'(ALUOP_MOV);
      (opcode == OP_JUMP):  dec_op = ALUOP_W'(ALUOP_JUMP);
      is_hold:              dec_hold = 1'b1;
      (opcode == OP_RTYPE): begin
        unique case (1'b1)
          (funct == FN_ADD): dec_op = ALUOP_W'(ALUOP_ADD);
          (funct == FN_SUB): dec_op = ALUOP_W'(ALUOP_SUB);
          (funct == FN_MUL): begin
            dec_op  = ALUOP_W'(ALUOP_MUL);
            dec_mul = 1'b1;
          end
          default:           dec_ok = 1'b0;
        endcase
      end
      default:              dec_ok = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aluop_d = aluop_q;
    ov_d    = 1'b0;
    ms_d    = 1'b0;
    ill_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (dec_hold) begin
              ov_d = 1'b1;
            end else if (!dec_ok) begin
              ov_d  = 1'b1;
              ill_d = (EXCEPT_ON_UNKNOWN != 0);
            end else begin
              aluop_d = dec_op;
              if (dec_mul) begin
                ms_d = 1'b1;
                if (MUL_LATENCY > 1) begin
                  state_d = BUSY;
                  cnt_d   = CW'(MUL_LATENCY - 1);
                end else begin
                  ov_d = 1'b1;
                end
              end else begin
                ov_d = 1'b1;
              end
            end
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            ov_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aluop_q <= '0;
      ov_q    <= 1'b0;
      ms_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aluop_q <= aluop_d;
      ov_q    <= ov_d;
      ms_q    <= ms_d;
      ill_q   <= ill_d;
    end
  end

  assign aluop_out   = aluop_q;
  assign out_valid   = ov_q;
  assign mul_start   = ms_q;
  assign illegal_out = ill_q;
  assign stall_out   = (state_q == BUSY);

endmodule
